// File: rtl/ans_rans_codec_pkg.sv
// Shared definitions for the rANS codec: default geometry, command
// encodings and the controller state enum.
package ans_rans_codec_pkg;

  localparam int DEF_SYM_W   = 4;
  localparam int DEF_PREC    = 6;
  localparam int DEF_DW      = 8;
  localparam int DEF_STATE_W = 16;
  localparam int DEF_LEN_W   = 16;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_ENC  = 2'b01,
    CMD_DEC  = 2'b10,
    CMD_LOAD = 2'b11
  } cmd_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_E_IN,
    S_E_RENORM,
    S_E_DIV,
    S_E_UPD,
    S_E_FLUSH,
    S_D_INIT,
    S_D_SYM,
    S_D_RENORM
  } state_e;

endpackage

// File: rtl/ans_rans_codec_freq_table.sv
// Frequency table for the rANS codec.
// Holds per-symbol counts f[] and registered cumulative starts c[], checks
// that the loaded counts sum to 2**PREC, and provides both the encode-side
// lookup (symbol -> f,c) and the decode-side parallel slot search
// (slot -> symbol,f,c).
// Ports:
//   clk, rst            clock, async active-high reset
//   ld_start            begin a new load (clears index, sum, tbl_vld)
//   ld_en, ld_cnt       write next count (symbol 0 first)
//   ld_done, ld_ok      final count being written / its sum is correct
//   tbl_vld             a correctly summed table is loaded
//   enc_sym/enc_f/enc_c encode lookup
//   slot/dec_sym/dec_f/dec_c decode lookup
module ans_rans_codec_freq_table #(
  parameter int SYM_W = 4,
  parameter int PREC  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_start,
  input  logic             ld_en,
  input  logic [PREC:0]    ld_cnt,
  output logic             ld_done,
  output logic             ld_ok,
  output logic             tbl_vld,
  input  logic [SYM_W-1:0] enc_sym,
  output logic [PREC:0]    enc_f,
  output logic [PREC:0]    enc_c,
  input  logic [PREC-1:0]  slot,
  output logic [SYM_W-1:0] dec_sym,
  output logic [PREC:0]    dec_f,
  output logic [PREC:0]    dec_c
);

  localparam int NSYM  = 2 ** SYM_W;
  localparam int SUM_W = SYM_W + PREC + 1;

  logic [PREC:0]    f_q [NSYM];
  logic [PREC:0]    c_q [NSYM];
  logic [SYM_W-1:0] idx_q;
  logic [SUM_W-1:0] sum_q;
  logic [SUM_W-1:0] sum_nxt;

  assign sum_nxt = sum_q + SUM_W'(ld_cnt);
  assign ld_done = ld_en && (idx_q == SYM_W'(NSYM - 1));
  assign ld_ok   = ld_done && (sum_nxt == SUM_W'(2 ** PREC));

  // c[s] is the running sum before f[s] is added; only meaningful when
  // the final sum checks out, so truncation on a bad table is harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSYM; i++) begin
        f_q[i] <= '0;
        c_q[i] <= '0;
      end
      idx_q   <= '0;
      sum_q   <= '0;
      tbl_vld <= 1'b0;
    end else if (ld_start) begin
      idx_q   <= '0;
      sum_q   <= '0;
      tbl_vld <= 1'b0;
    end else if (ld_en) begin
      f_q[idx_q] <= ld_cnt;
      c_q[idx_q] <= sum_q[PREC:0];
      sum_q      <= sum_nxt;
      idx_q      <= idx_q + 1'b1;
      if (ld_done) tbl_vld <= ld_ok;
    end
  end

  assign enc_f = f_q[enc_sym];
  assign enc_c = c_q[enc_sym];

  // Zero-count symbols own no slot; the 8-bit upper bound avoids overflow.
  always_comb begin
    dec_sym = '0;
    dec_f   = '0;
    dec_c   = '0;
    for (int s = 0; s < NSYM; s++) begin
      if ((f_q[s] != '0) && ({1'b0, slot} >= c_q[s]) &&
          ({2'b00, slot} < ({1'b0, c_q[s]} + {1'b0, f_q[s]}))) begin
        dec_sym = SYM_W'(s);
        dec_f   = f_q[s];
        dec_c   = c_q[s];
      end
    end
  end

endmodule

// File: rtl/ans_rans_codec.sv
// rANS encode/decode engine with table load, one mode per frame.
// Ports:
//   clk, rst                  clock, async active-high reset
//   cmd/cmd_len/cmd_vld/cmd_rdy  frame command (nop/enc/dec/load)
//   in/in_last/in_vld/in_rdy  input stream (symbol, count or coded word)
//   out/out_last/out_vld/out_rdy output stream (coded word or symbol)
//   tbl_vld                   valid table loaded
//   err                       sticky error, cleared on next accepted cmd
//
// state      | meaning
// IDLE       | waiting for a command
// LOAD       | accepting NSYM counts
// E_IN       | waiting for next symbol to encode
// E_RENORM   | emitting low bytes of x until it fits the symbol's range
// E_DIV      | restoring divide x/f, one quotient bit per cycle
// E_UPD      | x := (q<<PREC)+r+c
// E_FLUSH    | emitting final state, LS word first
// D_INIT     | shifting in initial state words
// D_SYM      | presenting decoded symbol
// D_RENORM   | refilling x from the stream while x < L
module ans_rans_codec
  import ans_rans_codec_pkg::*;
#(
  parameter int SYM_W   = DEF_SYM_W,
  parameter int PREC    = DEF_PREC,
  parameter int DW      = DEF_DW,
  parameter int STATE_W = DEF_STATE_W,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cmd,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_vld,
  output logic             cmd_rdy,
  input  logic [DW-1:0]    in,
  input  logic             in_last,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [DW-1:0]    out,
  output logic             out_last,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             tbl_vld,
  output logic             err
);

  localparam int QW     = STATE_W - PREC;
  localparam int NWORDS = STATE_W / DW;
  localparam int WC_W   = $clog2(NWORDS + 1);
  localparam int DC_W   = $clog2(QW + 1);
  localparam logic [STATE_W-1:0] X_L = STATE_W'(2 ** (STATE_W - DW));

  state_e              state_q, state_d;
  logic [STATE_W-1:0]  x_q;
  logic [SYM_W-1:0]    sym_q;
  logic                last_q;
  logic [LEN_W-1:0]    len_q;
  logic [WC_W-1:0]     wcnt_q;
  logic [DC_W-1:0]     div_cnt_q;
  logic [PREC:0]       div_rem_q;
  logic [QW-1:0]       div_sh_q;
  logic                err_q;

  logic                ld_start, ld_en, ld_done, ld_ok;
  logic [SYM_W-1:0]    enc_sym, dec_sym;
  logic [PREC:0]       enc_f, enc_c, dec_f, dec_c;
  logic                need_renorm, div_ge;
  logic [PREC+1:0]     div_trial;
  logic [STATE_W-1:0]  enc_x, dec_x;

  assign ld_start = (state_q == S_IDLE) && cmd_vld && (cmd == CMD_LOAD);
  assign ld_en    = (state_q == S_LOAD) && in_vld;
  // In E_IN the incoming symbol is looked up directly so f==0 is caught on accept.
  assign enc_sym  = (state_q == S_E_IN) ? in[SYM_W-1:0] : sym_q;

  ans_rans_codec_freq_table #(.SYM_W(SYM_W), .PREC(PREC)) u_tbl (
    .clk     (clk),
    .rst     (rst),
    .ld_start(ld_start),
    .ld_en   (ld_en),
    .ld_cnt  (in[PREC:0]),
    .ld_done (ld_done),
    .ld_ok   (ld_ok),
    .tbl_vld (tbl_vld),
    .enc_sym (enc_sym),
    .enc_f   (enc_f),
    .enc_c   (enc_c),
    .slot    (x_q[PREC-1:0]),
    .dec_sym (dec_sym),
    .dec_f   (dec_f),
    .dec_c   (dec_c)
  );

  // One bit wider than x so f==M never forces a renormalisation.
  assign need_renorm = {1'b0, x_q} >= {enc_f, {QW{1'b0}}};
  // Remainder starts at x>>QW (< f after renorm), so QW steps give the full quotient.
  assign div_trial   = {div_rem_q, div_sh_q[QW-1]};
  assign div_ge      = div_trial >= {1'b0, enc_f};
  assign enc_x       = {div_sh_q, {PREC{1'b0}}} + STATE_W'(div_rem_q) + STATE_W'(enc_c);
  // True result fits STATE_W bits, so modular arithmetic at that width is exact.
  assign dec_x       = STATE_W'(dec_f) * (x_q >> PREC) + STATE_W'(x_q[PREC-1:0]) - STATE_W'(dec_c);
  assign err         = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (cmd_vld) begin
        case (cmd)
          CMD_ENC:  if (tbl_vld) state_d = S_E_IN;
          CMD_DEC:  if (tbl_vld) state_d = S_D_INIT;
          CMD_LOAD: state_d = S_LOAD;
          default:  state_d = S_IDLE;
        endcase
      end
      S_LOAD:     if (ld_done) state_d = S_IDLE;
      S_E_IN:     if (in_vld) state_d = (enc_f == '0) ? S_IDLE : S_E_RENORM;
      S_E_RENORM: if (!need_renorm) state_d = S_E_DIV;
      S_E_DIV:    if (div_cnt_q == DC_W'(1)) state_d = S_E_UPD;
      S_E_UPD:    state_d = last_q ? S_E_FLUSH : S_E_IN;
      S_E_FLUSH:  if (out_rdy && (wcnt_q == WC_W'(1))) state_d = S_IDLE;
      S_D_INIT:   if (in_vld && (wcnt_q == WC_W'(1))) state_d = S_D_SYM;
      S_D_SYM:    if (out_rdy) state_d = (len_q == LEN_W'(1)) ? S_IDLE : S_D_RENORM;
      S_D_RENORM: if (x_q >= X_L) state_d = S_D_SYM;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_rdy  = 1'b0;
    in_rdy   = 1'b0;
    out_vld  = 1'b0;
    out      = '0;
    out_last = 1'b0;
    case (state_q)
      S_IDLE:                   cmd_rdy = 1'b1;
      S_LOAD, S_E_IN, S_D_INIT: in_rdy  = 1'b1;
      S_D_RENORM:               in_rdy  = x_q < X_L;
      S_E_RENORM: begin
        out_vld = need_renorm;
        if (need_renorm) out = x_q[DW-1:0];
      end
      S_E_FLUSH: begin
        out_vld  = 1'b1;
        out      = x_q[DW-1:0];
        out_last = wcnt_q == WC_W'(1);
      end
      S_D_SYM: begin
        out_vld  = 1'b1;
        out      = DW'(dec_sym);
        out_last = len_q == LEN_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q       <= '0;
      sym_q     <= '0;
      last_q    <= 1'b0;
      len_q     <= '0;
      wcnt_q    <= '0;
      div_cnt_q <= '0;
      div_rem_q <= '0;
      div_sh_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (cmd_vld) begin
          err_q  <= ((cmd == CMD_ENC) || (cmd == CMD_DEC)) && !tbl_vld;
          len_q  <= cmd_len;
          x_q    <= (cmd == CMD_ENC) ? X_L : '0;
          wcnt_q <= WC_W'(NWORDS);
        end
        S_LOAD: if (ld_done && !ld_ok) err_q <= 1'b1;
        S_E_IN: if (in_vld) begin
          sym_q  <= in[SYM_W-1:0];
          last_q <= in_last;
          if (enc_f == '0) err_q <= 1'b1;
        end
        S_E_RENORM: begin
          if (need_renorm) begin
            if (out_rdy) x_q <= x_q >> DW;
          end else begin
            div_rem_q <= (PREC+1)'(x_q[STATE_W-1:QW]);
            div_sh_q  <= x_q[QW-1:0];
            div_cnt_q <= DC_W'(QW);
          end
        end
        S_E_DIV: begin
          div_rem_q <= (PREC+1)'(div_ge ? div_trial - {1'b0, enc_f} : div_trial);
          div_sh_q  <= {div_sh_q[QW-2:0], div_ge};
          div_cnt_q <= div_cnt_q - 1'b1;
        end
        S_E_UPD: begin
          x_q    <= enc_x;
          wcnt_q <= WC_W'(NWORDS);
        end
        S_E_FLUSH: if (out_rdy) begin
          x_q    <= x_q >> DW;
          wcnt_q <= wcnt_q - 1'b1;
        end
        S_D_INIT: if (in_vld) begin
          x_q    <= {x_q[STATE_W-DW-1:0], in};
          wcnt_q <= wcnt_q - 1'b1;
        end
        S_D_SYM: if (out_rdy) begin
          x_q   <= dec_x;
          len_q <= len_q - 1'b1;
          if ((len_q == LEN_W'(1)) && (dec_x != X_L)) err_q <= 1'b1;
        end
        S_D_RENORM: if ((x_q < X_L) && in_vld) x_q <= {x_q[STATE_W-DW-1:0], in};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ans_rans_codec.sv
module tb_ans_rans_codec;
  import ans_rans_codec_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cmd;
  logic [15:0] cmd_len;
  logic        cmd_vld, cmd_rdy;
  logic [7:0]  in_data;
  logic        in_last, in_vld, in_rdy;
  logic [7:0]  out_data;
  logic        out_last, out_vld, out_rdy;
  logic        tbl_vld, err;

  int errors = 0;
  int checks = 0;

  ans_rans_codec dut (
    .clk(clk), .rst(rst),
    .cmd(cmd), .cmd_len(cmd_len), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .in(in_data), .in_last(in_last), .in_vld(in_vld), .in_rdy(in_rdy),
    .out(out_data), .out_last(out_last), .out_vld(out_vld), .out_rdy(out_rdy),
    .tbl_vld(tbl_vld), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] c, input logic [15:0] n);
    int k = 0;
    while (!cmd_rdy && k < 200) begin @(negedge clk); k++; end
    chk("cmd_rdy_wait", cmd_rdy, 1);
    cmd = c; cmd_len = n; cmd_vld = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d, input logic l, input string tag);
    int k = 0;
    in_data = d; in_last = l; in_vld = 1'b1;
    while (!in_rdy && k < 200) begin @(negedge clk); k++; end
    chk(tag, in_rdy, 1);
    @(negedge clk);
    in_vld = 1'b0; in_last = 1'b0;
  endtask

  task automatic recv_word(output logic [7:0] d, output logic l, input string tag);
    int k = 0;
    out_rdy = 1'b1;
    while (!out_vld && k < 200) begin @(negedge clk); k++; end
    chk(tag, out_vld, 1);
    d = out_data; l = out_last;
    @(negedge clk);
    out_rdy = 1'b0;
  endtask

  task automatic load_table(input logic [6:0] f [16]);
    send_cmd(CMD_LOAD, 16'd0);
    for (int i = 0; i < 16; i++) send_word({1'b0, f[i]}, 1'b0, "load_rdy");
  endtask

  logic [6:0]  tbl [16];
  logic [7:0]  w;
  logic        l;
  logic [3:0]  syms [200];
  logic [7:0]  words [$];
  int          idx, ptr, nsym, cyc;
  logic        done, in_hs, out_hs, stable, saw_out;
  logic [7:0]  cap_d;
  logic        cap_l;

  initial begin
    rst = 1'b1; cmd = '0; cmd_len = '0; cmd_vld = 1'b0;
    in_data = '0; in_last = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_out", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_err", err, 0);
    chk("rst_tbl_vld", tbl_vld, 0);
    chk("rst_cmd_rdy", cmd_rdy, 1);
    rst = 1'b0;
    @(negedge clk);

    // T1: uniform table
    for (int i = 0; i < 16; i++) tbl[i] = 7'd4;
    load_table(tbl);
    chk("t1_tbl_vld", tbl_vld, 1);
    chk("t1_err", err, 0);

    // T1b: sum 63
    tbl[15] = 7'd3;
    load_table(tbl);
    chk("t1b_err", err, 1);
    chk("t1b_tbl_vld", tbl_vld, 0);
    send_cmd(CMD_ENC, 16'd0);
    chk("t1b_enc_err", err, 1);
    chk("t1b_cmd_rdy", cmd_rdy, 1);
    chk("t1b_in_rdy", in_rdy, 0);

    // T2: encode s=5 -> 0x14, 0x10
    tbl[15] = 7'd4;
    load_table(tbl);
    chk("t2_tbl_vld", tbl_vld, 1);
    send_cmd(CMD_ENC, 16'd0);
    send_word(8'd5, 1'b1, "t2_in_rdy");
    recv_word(w, l, "t2_vld0");
    chk("t2_w0", w, 8'h14);
    chk("t2_l0", l, 0);
    recv_word(w, l, "t2_vld1");
    chk("t2_w1", w, 8'h10);
    chk("t2_l1", l, 1);
    chk("t2_err", err, 0);
    chk("t2_idle", cmd_rdy, 1);

    // T2b: decode N=1
    send_cmd(CMD_DEC, 16'd1);
    send_word(8'h10, 1'b0, "t2b_in0");
    send_word(8'h14, 1'b0, "t2b_in1");
    recv_word(w, l, "t2b_vld");
    chk("t2b_sym", w, 8'd5);
    chk("t2b_last", l, 1);
    chk("t2b_err", err, 0);
    chk("t2b_idle", cmd_rdy, 1);

    // T4: flush stalled 10 cycles
    send_cmd(CMD_ENC, 16'd0);
    send_word(8'd5, 1'b1, "t4_in_rdy");
    out_rdy = 1'b0;
    cyc = 0;
    while (!out_vld && cyc < 200) begin @(negedge clk); cyc++; end
    chk("t4_vld_wait", out_vld, 1);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!out_vld || out_data !== 8'h14 || out_last !== 1'b0) stable = 1'b0;
    end
    chk("t4_stable", stable, 1);
    recv_word(w, l, "t4_vld0");
    chk("t4_w0", w, 8'h14);
    chk("t4_l0", l, 0);
    recv_word(w, l, "t4_vld1");
    chk("t4_w1", w, 8'h10);
    chk("t4_l1", l, 1);
    chk("t4_no_dup", out_vld, 0);

    // T3: f[3]=0
    for (int i = 0; i < 16; i++) tbl[i] = 7'd4;
    tbl[0] = 7'd8; tbl[3] = 7'd0;
    load_table(tbl);
    chk("t3_tbl_vld", tbl_vld, 1);
    send_cmd(CMD_ENC, 16'd0);
    send_word(8'd3, 1'b1, "t3_in_rdy");
    saw_out = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_vld) saw_out = 1'b1;
      @(negedge clk);
    end
    chk("t3_no_out", saw_out, 0);
    chk("t3_err", err, 1);
    chk("t3_idle", cmd_rdy, 1);

    // T5: skewed table, 200 random symbols with stalls
    tbl[0] = 7'd40;
    for (int i = 1; i < 16; i++) tbl[i] = (i < 10) ? 7'd2 : 7'd1;
    load_table(tbl);
    chk("t5_tbl_vld", tbl_vld, 1);
    for (int i = 0; i < 200; i++)
      syms[i] = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(15));
    send_cmd(CMD_ENC, 16'd0);
    idx = 0; done = 1'b0; cyc = 0;
    while (!done && cyc < 30000) begin
      in_vld  = (idx < 200) && ($urandom_range(3) != 0);
      in_data = (idx < 200) ? {4'd0, syms[idx]} : 8'd0;
      in_last = (idx == 199);
      out_rdy = ($urandom_range(3) != 0);
      #1;
      in_hs = in_vld && in_rdy;
      out_hs = out_vld && out_rdy;
      cap_d = out_data; cap_l = out_last;
      @(negedge clk);
      cyc++;
      if (in_hs) idx++;
      if (out_hs) begin
        words.push_back(cap_d);
        if (cap_l) done = 1'b1;
      end
    end
    in_vld = 1'b0; in_last = 1'b0; out_rdy = 1'b0;
    chk("t5_enc_done", done, 1);
    chk("t5_enc_count", idx, 200);
    chk("t5_enc_err", err, 0);

    send_cmd(CMD_DEC, 16'd200);
    ptr = words.size() - 1; nsym = 0; done = 1'b0; cyc = 0;
    while (!done && cyc < 30000) begin
      in_vld  = $urandom_range(3) != 0;
      in_data = (ptr >= 0) ? words[ptr] : 8'd0;
      out_rdy = $urandom_range(3) != 0;
      #1;
      in_hs = in_vld && in_rdy;
      out_hs = out_vld && out_rdy;
      cap_d = out_data; cap_l = out_last;
      @(negedge clk);
      cyc++;
      if (in_hs) ptr--;
      if (out_hs) begin
        if (nsym < 200) chk("t5_sym", cap_d, {4'd0, syms[199-nsym]});
        chk("t5_last", cap_l, (nsym == 199) ? 1 : 0);
        nsym++;
        if (cap_l) done = 1'b1;
      end
    end
    in_vld = 1'b0; out_rdy = 1'b0;
    @(negedge clk);
    chk("t5_dec_done", done, 1);
    chk("t5_dec_count", nsym, 200);
    chk("t5_words_used", ptr, 32'hFFFF_FFFF);
    chk("t5_dec_err", err, 0);

    // T6: reset mid-divide
    send_cmd(CMD_ENC, 16'd0);
    send_word(8'd1, 1'b0, "t6_in_rdy");
    repeat (3) @(negedge clk);
    chk("t6_pre_tbl", tbl_vld, 1);
    rst = 1'b1;
    #1;
    chk("t6_out_vld", out_vld, 0);
    chk("t6_in_rdy", in_rdy, 0);
    chk("t6_tbl_vld", tbl_vld, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_cmd_rdy", cmd_rdy, 1);
    chk("t6_tbl_after", tbl_vld, 0);
    chk("t6_err", err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
